// File: rtl/rr_word_arbiter.sv
// rr_word_arbiter: round-robin share of one word channel among 2**W_SEL requesters.
// Optional RR_WORD_ARB_FIXED_PRI_EN selects fixed lowest-index priority instead.
module rr_word_arbiter #(
  parameter int W_WRD = 32,
  parameter int W_SEL = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [(1<<W_SEL)-1:0]           req,
  input  logic [(1<<W_SEL)*W_WRD-1:0]     bus,
  output logic [W_WRD-1:0]                out_dat,
  output logic [W_SEL-1:0]                out_sel,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [(1<<W_SEL)-1:0]           done,
  output logic [(1<<W_SEL)-1:0]           pend
);

  localparam int N_REQ = 1 << W_SEL;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] req_dly_q;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [W_WRD-1:0] dat_q, dat_d;
  logic [W_SEL-1:0] sel_q, sel_d;
  logic             vld_q, vld_d;
  logic [N_REQ-1:0] edg, clr, sel_oh;
  logic [W_SEL-1:0] start_idx, scan_idx, grant_idx;
  logic             found;

`ifdef RR_WORD_ARB_FIXED_PRI_EN
  assign start_idx = '0;
`else
  logic [W_SEL-1:0] ptr_q, ptr_d;
  assign start_idx = ptr_q;
`endif

  assign edg    = req & ~req_dly_q;
  assign sel_oh = {{(N_REQ-1){1'b0}}, 1'b1} << sel_q;

  // Scan pending flags upward from start_idx with wrap; first hit wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = start_idx + W_SEL'(k);
      if (!found && pend_q[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Grant / accept state machine next-state logic.
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    done_d  = '0;
    clr     = '0;
`ifndef RR_WORD_ARB_FIXED_PRI_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d   = grant_idx;
          dat_d   = bus[W_WRD*int'(grant_idx) +: W_WRD];
          vld_d   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (vld_q && out_rdy) begin
          vld_d   = 1'b0;
          done_d  = sel_oh;
          clr     = sel_oh;
`ifndef RR_WORD_ARB_FIXED_PRI_EN
          ptr_d   = sel_q + 1'b1;
`endif
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pend_d = edg | (pend_q & ~clr);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_dly_q <= '0;
      pend_q    <= '0;
      done_q    <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      vld_q     <= 1'b0;
`ifndef RR_WORD_ARB_FIXED_PRI_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_dly_q <= req;
      pend_q    <= pend_d;
      done_q    <= done_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      vld_q     <= vld_d;
`ifndef RR_WORD_ARB_FIXED_PRI_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign out_dat = dat_q;
  assign out_sel = sel_q;
  assign out_vld = vld_q;
  assign done    = done_q;
  assign pend    = pend_q;

endmodule

// File: tb/tb_rr_word_arbiter.sv
// tb_rr_word_arbiter: directed plus random checks against a cycle reference model.
// Honors RR_WORD_ARB_FIXED_PRI_EN for expected grant order.
module tb_rr_word_arbiter;

  localparam int W = 32;
  localparam int S = 2;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] bus;
  logic [W-1:0]   out_dat;
  logic [S-1:0]   out_sel;
  logic           out_vld;
  logic           out_rdy;
  logic [N-1:0]   done;
  logic [N-1:0]   pend;

  rr_word_arbiter #(.W_WRD(W), .W_SEL(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .bus     (bus),
    .out_dat (out_dat),
    .out_sel (out_sel),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .done    (done),
    .pend    (pend)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_prev = '0;
  logic [N-1:0] m_done = '0;
  logic [W-1:0] m_dat  = '0;
  int           m_ptr  = 0;
  int           m_sel  = 0;
  bit           m_vld  = 1'b0;

  int  obs_q[$];
  bit  vld_prev = 1'b0;
  int  done_cnt;

  task automatic model_step();
    logic [N-1:0] np;
    int start, g;
    if (rst) begin
      m_pend = '0; m_prev = '0; m_done = '0;
      m_dat = '0; m_ptr = 0; m_sel = 0; m_vld = 1'b0;
    end else begin
      np = m_pend;
      m_done = '0;
      if (m_vld) begin
        if (out_rdy) begin
          np[m_sel] = 1'b0;
          m_done[m_sel] = 1'b1;
          m_vld = 1'b0;
          m_ptr = (m_sel + 1) % N;
        end
      end else if (m_pend != 0) begin
`ifdef RR_WORD_ARB_FIXED_PRI_EN
        start = 0;
`else
        start = m_ptr;
`endif
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && m_pend[(start + k) % N]) g = (start + k) % N;
        m_sel = g;
        m_dat = bus[g*W +: W];
        m_vld = 1'b1;
      end
      for (int i = 0; i < N; i++)
        if (req[i] && !m_prev[i]) np[i] = 1'b1;
      m_prev = req;
      m_pend = np;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("vld", 64'(out_vld), 64'(m_vld));
    chk("sel", 64'(out_sel), 64'(m_sel));
    chk("dat", 64'(out_dat), 64'(m_dat));
    chk("done", 64'(done), 64'(m_done));
    chk("pend", 64'(pend), 64'(m_pend));
    if (out_vld && !vld_prev) obs_q.push_back(int'(out_sel));
    vld_prev = out_vld;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int qcode();
    int c = obs_q.size();
    foreach (obs_q[i]) c = c * 8 + obs_q[i];
    return c;
  endfunction

  function automatic int ecode(input int n, input int a, input int b,
                               input int c);
    int r = n;
    if (n > 0) r = r * 8 + a;
    if (n > 1) r = r * 8 + b;
    if (n > 2) r = r * 8 + c;
    return r;
  endfunction

  initial begin
    rst = 1'b1; req = '0; bus = '0; out_rdy = 1'b0;
    tick();
    tick();
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_pend", 64'(pend), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // single request
    out_rdy = 1'b1;
    bus[2*W +: W] = 32'hDEADBEEF;
    req = 4'b0100;
    tick();
    chk("single_vld_e0", 64'(out_vld), 64'd0);
    tick();
    chk("single_vld_e1", 64'(out_vld), 64'd1);
    chk("single_dat", 64'(out_dat), 64'hDEADBEEF);
    chk("single_sel", 64'(out_sel), 64'd2);
    tick();
    chk("single_done", 64'(done), 64'b0100);
    chk("single_pend", 64'(pend), 64'd0);
    req = '0;
    run(2);

    // round-robin order, twice
    do_reset();
    obs_q.delete();
    req = 4'b1011;
    run(8);
    chk("rr_order1", 64'(qcode()), 64'(ecode(3, 0, 1, 3)));
    req = '0;
    tick();
    obs_q.delete();
    req = 4'b1011;
    run(8);
    chk("rr_order2", 64'(qcode()), 64'(ecode(3, 0, 1, 3)));
    req = '0;
    run(2);

    // fairness
    do_reset();
    req = 4'b0010;
    run(4);
    req = '0;
    tick();
    obs_q.delete();
`ifdef RR_WORD_ARB_FIXED_PRI_EN
    req = 4'b1010;
    run(6);
    chk("fair_order", 64'(qcode()), 64'(ecode(2, 1, 3, 0)));
`else
    req = 4'b0011;
    run(6);
    chk("fair_order", 64'(qcode()), 64'(ecode(2, 0, 1, 0)));
`endif
    req = '0;

    // backpressure and word stability
    do_reset();
    out_rdy = 1'b0;
    bus[0 +: W] = 32'h12345678;
    req = 4'b0001;
    run(2);
    req = '0;
    for (int i = 0; i < 10; i++) begin
      bus = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("bp_dat", 64'(out_dat), 64'h12345678);
      chk("bp_vld", 64'(out_vld), 64'd1);
    end
    out_rdy = 1'b1;
    tick();
    chk("bp_done", 64'(done), 64'b0001);
    tick();
    chk("bp_done_off", 64'(done), 64'd0);

    // collision on accept edge
    do_reset();
    out_rdy = 1'b0;
    req = 4'b1100;
    run(2);
    chk("col_sel", 64'(out_sel), 64'd2);
    req = '0;
    tick();
    obs_q.delete();
    req = 4'b0100;
    out_rdy = 1'b1;
    tick();
    chk("col_pend", 64'(pend), 64'b1100);
    run(6);
`ifdef RR_WORD_ARB_FIXED_PRI_EN
    chk("col_order", 64'(qcode()), 64'(ecode(2, 2, 3, 0)));
`else
    chk("col_order", 64'(qcode()), 64'(ecode(2, 3, 2, 0)));
`endif
    req = '0;

    // reset mid-transfer
    do_reset();
    out_rdy = 1'b0;
    req = 4'b1011;
    run(2);
    chk("mid_pend", 64'(pend), 64'b1011);
    chk("mid_vld", 64'(out_vld), 64'd1);
    req = 4'b0010;
    rst = 1'b1;
    tick();
    chk("mid_rst_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_pend", 64'(pend), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_dat", 64'(out_dat), 64'd0);
    rst = 1'b0;
    out_rdy = 1'b1;
    obs_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      done_cnt += $countones(done);
    end
    chk("mid_done_cnt", 64'(done_cnt), 64'd1);
    chk("mid_order", 64'(qcode()), 64'(ecode(1, 1, 0, 0)));
    req = '0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom_range(0, 15));
      bus = {$urandom, $urandom, $urandom, $urandom};
      out_rdy = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
